bc_orbit_counter: RTL

//  Parametrised bunch-crossing (BC) / orbit counter.
//  - BC counter: wraps 0..LSB_CNT_MAX-1. Orbit counter: increments on each BC wrap.
//  - Aligns to an external orbit marker (resync_i) and tracks lock.
//  - Flags misaligned markers. Drops lock after MISS_MAX consecutive misaligned markers.
//  - Sits after the timing receiver; feeds BCID/orbit tags to the readout logic.

---
 rtl/bc_orbit_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bc_orbit_counter.sv
// Bunch-crossing / orbit counter with orbit-marker alignment, lock tracking
// and misaligned-marker flagging.
module bc_orbit_counter #(
    parameter int unsigned LSB_CNT_MAX = 3564,
    parameter int unsigned LSB_W       = 12,
    parameter int unsigned MSB_W       = 24,
    parameter int unsigned BC_OFFSET   = 0,
    parameter int unsigned MISS_MAX    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync_i,
    input  logic             orbit_clr_i,
    input  logic             err_clr_i,
    output logic [LSB_W-1:0] bcid_o,
    output logic [MSB_W-1:0] orbit_o,
    output logic             bc0_o,
    output logic             locked_o,
    output logic             resync_err_o,
    output logic [1:0]       miss_cnt_o
);

    localparam int unsigned MISS_W  = (MISS_MAX < 3) ? 2 : $clog2(MISS_MAX + 1);
    localparam int unsigned EXP_BC  = (BC_OFFSET == 0) ? (LSB_CNT_MAX - 1) : (BC_OFFSET - 1);
    localparam logic [LSB_W-1:0]  BC_LAST  = LSB_W'(LSB_CNT_MAX - 1);
    localparam logic [LSB_W-1:0]  BC_EXP   = LSB_W'(EXP_BC);
    localparam logic [LSB_W-1:0]  BC_LOAD  = LSB_W'(BC_OFFSET);
    localparam logic [MISS_W-1:0] MISS_TOP = MISS_W'(MISS_MAX);
    localparam logic              LOAD_IS_ZERO = (BC_OFFSET == 0);

    typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LSB_W-1:0]    r_bcid;
    logic [MSB_W-1:0]    r_orbit;
    logic                r_bc0;
    logic                r_err;
    logic [MISS_W-1:0]   r_miss;
    logic [1:0]          r_miss_sat;

    logic                w_wrap;
    logic                w_aligned;
    logic                w_miss_locked;
    logic [LSB_W-1:0]    w_bc_adv;
    logic [MISS_W-1:0]   w_miss_inc;
    logic [LSB_W-1:0]    w_bcid_nxt;
    logic [MSB_W-1:0]    w_orbit_nxt;
    logic                w_bc0_nxt;
    logic                w_err_nxt;
    logic [MISS_W-1:0]   w_miss_nxt;
    logic [1:0]          w_miss_sat_nxt;

    assign w_wrap        = (r_bcid == BC_LAST);
    assign w_aligned     = (r_bcid == BC_EXP);
    assign w_bc_adv      = w_wrap ? '0 : r_bcid + LSB_W'(1);
    assign w_miss_inc    = (r_miss == MISS_TOP) ? r_miss : r_miss + MISS_W'(1);
    assign w_miss_locked = resync_i && !w_aligned && (r_state == S_LOCKED);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: only a marker seen while enabled moves the lock state
    always_comb begin
        w_state_nxt = r_state;
        if (en && resync_i) begin
            case (r_state)
                S_UNLOCKED: w_state_nxt = S_LOCKED;
                S_LOCKED: begin
                    if (!w_aligned && (w_miss_inc == MISS_TOP)) begin
                        w_state_nxt = S_UNLOCKED;
                    end
                end
                default: w_state_nxt = S_UNLOCKED;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        locked_o = (r_state == S_LOCKED);
    end

    // Counter, orbit, error and miss-count next values
    always_comb begin
        w_bcid_nxt  = r_bcid;
        w_orbit_nxt = r_orbit;
        w_bc0_nxt   = 1'b0;
        w_err_nxt   = r_err;
        w_miss_nxt  = r_miss;
        if (en) begin
            if (resync_i) begin
                w_bcid_nxt = BC_LOAD;
                w_bc0_nxt  = LOAD_IS_ZERO;
            end else begin
                w_bcid_nxt = w_bc_adv;
                w_bc0_nxt  = w_wrap;
            end

            if (orbit_clr_i) begin
                w_orbit_nxt = '0;
            end else if ((!resync_i && w_wrap) || (resync_i && w_aligned && LOAD_IS_ZERO)) begin
                w_orbit_nxt = r_orbit + MSB_W'(1);
            end

            if (err_clr_i) begin
                w_err_nxt = 1'b0;
            end
            if (w_miss_locked) begin
                w_err_nxt = 1'b1;
            end

            if (resync_i) begin
                if (r_state == S_LOCKED && !w_aligned) begin
                    w_miss_nxt = w_miss_inc;
                end else begin
                    w_miss_nxt = '0;
                end
            end
        end
        w_miss_sat_nxt = (w_miss_nxt > MISS_W'(3)) ? 2'd3 : w_miss_nxt[1:0];
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcid     <= '0;
            r_orbit    <= '0;
            r_bc0      <= 1'b0;
            r_err      <= 1'b0;
            r_miss     <= '0;
            r_miss_sat <= 2'd0;
        end else begin
            r_bcid     <= w_bcid_nxt;
            r_orbit    <= w_orbit_nxt;
            r_bc0      <= w_bc0_nxt;
            r_err      <= w_err_nxt;
            r_miss     <= w_miss_nxt;
            r_miss_sat <= w_miss_sat_nxt;
        end
    end

    assign bcid_o       = r_bcid;
    assign orbit_o      = r_orbit;
    assign bc0_o        = r_bc0;
    assign resync_err_o = r_err;
    assign miss_cnt_o   = r_miss_sat;

endmodule
